// File: rtl/fifo_multi_chan.sv
// rtl/fifo_multi_chan.sv - NCH independent synchronous FIFOs with thresholds and sticky error flags
module fifo_multi_chan #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int NCH        = 2,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH*DATA_WIDTH-1:0] din,
    input  logic [NCH-1:0]            write,
    output logic [NCH-1:0]            full,
    output logic [NCH-1:0]            almost_full,
    output logic [NCH*DATA_WIDTH-1:0] dout,
    input  logic [NCH-1:0]            read,
    output logic [NCH-1:0]            empty,
    output logic [NCH-1:0]            almost_empty,
    output logic [NCH*CW-1:0]         count,
    output logic [NCH-1:0]            overflow,
    output logic [NCH-1:0]            underflow,
    input  logic                      err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         wr_ptr;
        logic [PW-1:0]         rd_ptr;
        logic [CW-1:0]         cnt;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  ovf;
        logic                  unf;
        logic                  is_full;
        logic                  is_empty;
        logic                  wr_ok;
        logic                  rd_ok;

        // Flags decode the registered count only, so they never depend on this cycle's requests.
        assign is_full  = (cnt == FULL_CNT);
        assign is_empty = (cnt == '0);
        assign wr_ok    = write[c] && !is_full;
        assign rd_ok    = read[c] && !is_empty;

        always_ff @(posedge clk) begin
            if (wr_ok) begin
                mem[wr_ptr] <= din[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                rdata  <= '0;
                ovf    <= 1'b0;
                unf    <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
                end
                if (rd_ok) begin
                    rdata  <= mem[rd_ptr];
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
                end
                if (wr_ok && !rd_ok) begin
                    cnt <= cnt + CW'(1);
                end else if (rd_ok && !wr_ok) begin
                    cnt <= cnt - CW'(1);
                end
                // A clear on the same edge wins over a new error.
                if (err_clr) begin
                    ovf <= 1'b0;
                    unf <= 1'b0;
                end else begin
                    if (write[c] && is_full) begin
                        ovf <= 1'b1;
                    end
                    if (read[c] && is_empty) begin
                        unf <= 1'b1;
                    end
                end
            end
        end

        assign dout[c*DATA_WIDTH +: DATA_WIDTH] = rdata;
        assign count[c*CW +: CW]                = cnt;
        assign full[c]                          = is_full;
        assign empty[c]                         = is_empty;
        assign almost_full[c]                   = (cnt >= AF_CNT);
        assign almost_empty[c]                  = (cnt <= AE_CNT);
        assign overflow[c]                      = ovf;
        assign underflow[c]                     = unf;
    end

endmodule

// File: tb/tb_fifo_multi_chan.sv
// tb/tb_fifo_multi_chan.sv - self-checking bench for fifo_multi_chan (DEPTH 8 and DEPTH 6 instances)
module tb_fifo_multi_chan;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] din_a, dout_a, din_b, dout_b;
    logic [1:0]  write_a, read_a, full_a, af_a, empty_a, ae_a, ovf_a, unf_a;
    logic [1:0]  write_b, read_b, full_b, af_b, empty_b, ae_b, ovf_b, unf_b;
    logic        clr_a, clr_b;
    logic [7:0]  count_a;
    logic [5:0]  count_b;

    fifo_multi_chan #(.DATA_WIDTH(8), .DEPTH(8), .NCH(2)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .write(write_a), .full(full_a),
        .almost_full(af_a), .dout(dout_a), .read(read_a), .empty(empty_a),
        .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(unf_a),
        .err_clr(clr_a)
    );

    fifo_multi_chan #(.DATA_WIDTH(8), .DEPTH(6), .NCH(2)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .write(write_b), .full(full_b),
        .almost_full(af_b), .dout(dout_b), .read(read_b), .empty(empty_b),
        .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(unf_b),
        .err_clr(clr_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per (instance, channel), index = inst*2 + ch.
    logic [7:0] mq [4][$];
    logic [7:0] mdout [4];
    logic       movf [4];
    logic       munf [4];

    typedef struct {
        logic [1:0]  w;
        logic [1:0]  r;
        logic [15:0] d;
        logic        clr;
        int          cnt0;
        int          cnt1;
        logic [7:0]  dout0;
        logic [7:0]  dout1;
        logic [1:0]  ovf;
        logic [1:0]  unf;
    } vec_t;

    vec_t tbl [$];

    function automatic int dep(input int inst);
        return (inst == 0) ? 8 : 6;
    endfunction

    function automatic vec_t mk(input logic [1:0] w, input logic [1:0] r, input logic [15:0] d,
                                input logic clr, input int c0, input int c1,
                                input logic [7:0] o0, input logic [7:0] o1,
                                input logic [1:0] ov, input logic [1:0] un);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.clr = clr; v.cnt0 = c0; v.cnt1 = c1;
        v.dout0 = o0; v.dout1 = o1; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mdout[k] = 8'h00;
            movf[k]  = 1'b0;
            munf[k]  = 1'b0;
        end
    endtask

    task automatic model_upd(input int inst, input int ch, input logic w, input logic r,
                             input logic [7:0] d, input logic clr);
        int  k;
        int  sz;
        logic f, e;
        k  = inst * 2 + ch;
        sz = mq[k].size();
        f  = (sz == dep(inst));
        e  = (sz == 0);
        if (clr) begin
            movf[k] = 1'b0;
            munf[k] = 1'b0;
        end else begin
            if (w && f) movf[k] = 1'b1;
            if (r && e) munf[k] = 1'b1;
        end
        if (r && !e) mdout[k] = mq[k].pop_front();
        if (w && !f) mq[k].push_back(d);
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                int         k;
                int         sz;
                int         d;
                logic [7:0] a_cnt, a_dout;
                logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
                k  = i * 2 + c;
                sz = mq[k].size();
                d  = dep(i);
                if (i == 0) begin
                    a_cnt = 8'(count_a[c*4 +: 4]); a_dout = dout_a[c*8 +: 8];
                    a_full = full_a[c]; a_empty = empty_a[c]; a_af = af_a[c]; a_ae = ae_a[c];
                    a_ovf = ovf_a[c]; a_unf = unf_a[c];
                end else begin
                    a_cnt = 8'(count_b[c*3 +: 3]); a_dout = dout_b[c*8 +: 8];
                    a_full = full_b[c]; a_empty = empty_b[c]; a_af = af_b[c]; a_ae = ae_b[c];
                    a_ovf = ovf_b[c]; a_unf = unf_b[c];
                end
                chk($sformatf("d%0d.ch%0d count", i, c), 32'(a_cnt), 32'(sz));
                chk($sformatf("d%0d.ch%0d dout", i, c), 32'(a_dout), 32'(mdout[k]));
                chk($sformatf("d%0d.ch%0d full", i, c), 32'(a_full), 32'(sz == d));
                chk($sformatf("d%0d.ch%0d empty", i, c), 32'(a_empty), 32'(sz == 0));
                chk($sformatf("d%0d.ch%0d almost_full", i, c), 32'(a_af), 32'(sz >= d - 2));
                chk($sformatf("d%0d.ch%0d almost_empty", i, c), 32'(a_ae), 32'(sz <= 2));
                chk($sformatf("d%0d.ch%0d overflow", i, c), 32'(a_ovf), 32'(movf[k]));
                chk($sformatf("d%0d.ch%0d underflow", i, c), 32'(a_unf), 32'(munf[k]));
            end
        end
    endtask

    task automatic step(input logic [1:0] wa, input logic [1:0] ra, input logic [15:0] da,
                        input logic ca, input logic [1:0] wb, input logic [1:0] rb,
                        input logic [15:0] db, input logic cb);
        write_a = wa; read_a = ra; din_a = da; clr_a = ca;
        write_b = wb; read_b = rb; din_b = db; clr_b = cb;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            model_upd(0, c, wa[c], ra[c], da[c*8 +: 8], ca);
            model_upd(1, c, wb[c], rb[c], db[c*8 +: 8], cb);
        end
        #1;
        check_model();
        write_a = 2'b00; read_a = 2'b00; clr_a = 1'b0;
        write_b = 2'b00; read_b = 2'b00; clr_b = 1'b0;
    endtask

    task automatic check_table(input int n, input vec_t v);
        int cnt[2];
        cnt[0] = v.cnt0;
        cnt[1] = v.cnt1;
        chk($sformatf("vec%0d count0", n), 32'(count_a[3:0]), 32'(v.cnt0));
        chk($sformatf("vec%0d count1", n), 32'(count_a[7:4]), 32'(v.cnt1));
        chk($sformatf("vec%0d dout0", n), 32'(dout_a[7:0]), 32'(v.dout0));
        chk($sformatf("vec%0d dout1", n), 32'(dout_a[15:8]), 32'(v.dout1));
        chk($sformatf("vec%0d overflow", n), 32'(ovf_a), 32'(v.ovf));
        chk($sformatf("vec%0d underflow", n), 32'(unf_a), 32'(v.unf));
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("vec%0d full%0d", n, c), 32'(full_a[c]), 32'(cnt[c] == 8));
            chk($sformatf("vec%0d empty%0d", n, c), 32'(empty_a[c]), 32'(cnt[c] == 0));
            chk($sformatf("vec%0d af%0d", n, c), 32'(af_a[c]), 32'(cnt[c] >= 6));
            chk($sformatf("vec%0d ae%0d", n, c), 32'(ae_a[c]), 32'(cnt[c] <= 2));
        end
    endtask

    initial begin
        write_a = '0; read_a = '0; din_a = '0; clr_a = 1'b0;
        write_b = '0; read_b = '0; din_b = '0; clr_b = 1'b0;

        // Directed vectors for the DEPTH=8 instance, starting from reset.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(2'b01, 2'b00, {8'h00, 8'(8'h11 + i)}, 1'b0, i + 1, 0, 8'h00, 8'h00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b01, 2'b00, 16'h00AA, 1'b0, 8, 0, 8'h00, 8'h00, 2'b01, 2'b00));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(2'b00, 2'b01, 16'h0000, 1'b0, 7 - k, 0, 8'(8'h11 + k), 8'h00, 2'b01, 2'b00));
        tbl.push_back(mk(2'b00, 2'b00, 16'h0000, 1'b1, 0, 0, 8'h18, 8'h00, 2'b00, 2'b00));
        for (int j = 0; j < 3; j++)
            tbl.push_back(mk(2'b10, 2'b00, {8'(8'h51 + j), 8'h00}, 1'b0, 0, j + 1, 8'h18, 8'h00, 2'b00, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 16'h5C00, 1'b0, 0, 3, 8'h18, 8'h51, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b10, 16'h0000, 1'b0, 0, 2, 8'h18, 8'h52, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b10, 16'h0000, 1'b0, 0, 1, 8'h18, 8'h53, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b10, 16'h0000, 1'b0, 0, 0, 8'h18, 8'h5C, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b10, 16'h0000, 1'b0, 0, 0, 8'h18, 8'h5C, 2'b00, 2'b10));
        tbl.push_back(mk(2'b01, 2'b01, 16'h0077, 1'b0, 1, 0, 8'h18, 8'h5C, 2'b00, 2'b11));
        tbl.push_back(mk(2'b00, 2'b01, 16'h0000, 1'b1, 0, 0, 8'h77, 8'h5C, 2'b00, 2'b00));
        tbl.push_back(mk(2'b00, 2'b01, 16'h0000, 1'b1, 0, 0, 8'h77, 8'h5C, 2'b00, 2'b00));

        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[n]) begin
            step(tbl[n].w, tbl[n].r, tbl[n].d, tbl[n].clr, 2'b00, 2'b00, 16'h0000, 1'b0);
            check_table(n, tbl[n]);
        end

        // Steady-state interleave at count 4 across pointer wrap, both depths.
        for (int i = 0; i < 4; i++)
            step(2'b01, 2'b00, {8'h00, 8'(8'hA0 + i)}, 1'b0, 2'b01, 2'b00, {8'h00, 8'(8'hB0 + i)}, 1'b0);
        for (int i = 0; i < 20; i++)
            step(2'b01, 2'b01, 16'($urandom), 1'b0, 2'b01, 2'b01, 16'($urandom), 1'b0);
        for (int i = 0; i < 4; i++)
            step(2'b00, 2'b01, 16'h0000, 1'b0, 2'b00, 2'b01, 16'h0000, 1'b0);

        // Asynchronous reset between edges with data held.
        for (int i = 0; i < 5; i++)
            step(2'b01, 2'b00, {8'h00, 8'(8'hC0 + i)}, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        step(2'b00, 2'b01, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        step(2'b01, 2'b00, 16'h00C5, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async reset count0", 32'(count_a[3:0]), 32'd0);
        chk("async reset empty0", 32'(empty_a[0]), 32'd1);
        chk("async reset dout0", 32'(dout_a[7:0]), 32'd0);
        check_model();
        @(negedge clk);
        rst = 1'b1;
        step(2'b01, 2'b00, 16'h0001, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        step(2'b00, 2'b01, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0);
        chk("post reset dout0", 32'(dout_a[7:0]), 32'h01);

        // Randomized traffic with drifting write/read bias to reach both boundaries.
        for (int n = 0; n < 600; n++) begin
            int pw;
            logic [1:0] wa, ra, wb, rb;
            pw = ((n / 100) % 2 == 0) ? 75 : 25;
            for (int c = 0; c < 2; c++) begin
                wa[c] = ($urandom_range(0, 99) < pw);
                ra[c] = ($urandom_range(0, 99) < 100 - pw);
                wb[c] = ($urandom_range(0, 99) < pw);
                rb[c] = ($urandom_range(0, 99) < 100 - pw);
            end
            step(wa, ra, 16'($urandom), ($urandom_range(0, 19) == 0),
                 wb, rb, 16'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
